// File: rtl/vertex_sched.sv
// Triangle-list sequencer: fetches 15-word triangle records from memory and presents
// them, together with the host-programmed 4x4 matrix, to the vertex transform stage.
module vertex_sched #(
  parameter int REC_STRIDE = 16,
  parameter int CNT_W      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cfg_write,
  input  logic [4:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic                   mem_read,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic [15:0][31:0]      mat,
  output logic [14:0][31:0]      v_out,
  output logic [23:0]            color_out1,
  output logic [23:0]            color_out2,
  output logic [23:0]            color_out3,
  output logic                   tri_valid,
  input  logic                   stall_in,
  output logic                   busy,
  output logic                   done_out,
  output logic [CNT_W-1:0]       tri_issued
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [15:0][31:0]    r_mat;
  logic [31:0]          r_base;
  logic [CNT_W-1:0]     r_count;
  logic [31:0]          r_ptr;
  logic [3:0]           r_idx;
  logic [14:0][31:0]    r_v;
  logic [CNT_W-1:0]     r_issued;

  logic w_start, w_cfg_we, w_ack, w_last, w_xfer, w_more;

  assign w_start  = cfg_write && (cfg_addr == 5'd18) && cfg_wdata[0] && (r_state == S_IDLE);
  assign w_cfg_we = cfg_write && (r_state == S_IDLE);
  assign w_ack    = (r_state == S_FETCH) && mem_ack;
  assign w_last   = w_ack && (r_idx == 4'd14);
  assign w_xfer   = (r_state == S_ISSUE) && !stall_in;
  assign w_more   = (r_issued + CNT_W'(1)) < r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (r_count != '0) ? S_FETCH : S_DONE;
      S_FETCH: if (w_last)  w_next = S_ISSUE;
      S_ISSUE: if (w_xfer)  w_next = w_more ? S_FETCH : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Config registers are locked while a run is in progress so mat stays constant per run.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mat     <= '0;
      r_mat[0]  <= 32'h0001_0000;
      r_mat[5]  <= 32'h0001_0000;
      r_mat[10] <= 32'h0001_0000;
      r_mat[15] <= 32'h0001_0000;
      r_base    <= '0;
      r_count   <= '0;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_v       <= '0;
      r_issued  <= '0;
    end else begin
      if (w_cfg_we) begin
        if (!cfg_addr[4])            r_mat[cfg_addr[3:0]] <= cfg_wdata;
        else if (cfg_addr == 5'd16)  r_base  <= cfg_wdata;
        else if (cfg_addr == 5'd17)  r_count <= cfg_wdata[CNT_W-1:0];
      end
      if (w_start) begin
        r_issued <= '0;
        r_ptr    <= r_base;
        r_idx    <= '0;
      end
      if (w_ack) begin
        r_v[r_idx] <= mem_rdata;
        r_idx      <= r_idx + 4'd1;
      end
      if (w_xfer) begin
        r_issued <= r_issued + CNT_W'(1);
        r_ptr    <= r_ptr + 32'(REC_STRIDE);
        r_idx    <= '0;
      end
    end
  end

  assign mem_read   = (r_state == S_FETCH);
  assign mem_addr   = mem_read ? (r_ptr + 32'(r_idx)) : '0;
  assign mat        = r_mat;
  assign v_out      = r_v;
  assign color_out1 = r_v[3][23:0];
  assign color_out2 = r_v[7][23:0];
  assign color_out3 = r_v[11][23:0];
  assign tri_valid  = (r_state == S_ISSUE);
  assign busy       = (r_state != S_IDLE);
  assign done_out   = (r_state == S_DONE);
  assign tri_issued = r_issued;

endmodule
